// File: rtl/wb_mem_responder_if.sv
// Wishbone-classic bus bundle between the core (master) and the memory responder (slave).
interface wb_mem_responder_if;
    logic [29:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] dat_r;
    logic        ack;

    modport master (
        output adr, dat_w, sel, we, cyc,
        input  dat_r, ack
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc,
        output dat_r, ack
    );
endinterface

// File: rtl/wb_mem_responder.sv
// Wishbone-classic memory responder: word array with wait states, exit mailbox,
// run cycle counter and watchdog, usable without a behavioural memory model.
module wb_mem_responder #(
    parameter int unsigned DEPTH_LOG2     = 17,
    parameter int unsigned WAIT_STATES    = 1,
    parameter logic [29:0] EXIT_ADR       = 30'h0400_0001,
    parameter logic [31:0] EXIT_DATA      = 32'h0000_00AD,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic                clk,
    input  logic                resetn,
    wb_mem_responder_if.slave   wb_io,
    output logic                done_o,
    output logic                timeout_o,
    output logic [31:0]         cycle_count_o
);

    localparam int unsigned DEPTH   = 2 ** DEPTH_LOG2;
    localparam int unsigned WCNT_W  = 4;
    localparam logic [WCNT_W-1:0] WAIT_INIT =
        (WAIT_STATES == 0) ? '0 : WCNT_W'(WAIT_STATES - 1);
    localparam logic [31:0] TIMEOUT_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_FINAL = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_HALT
    } state_e;

    typedef struct packed {
        logic [29:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } req_t;

    state_e              state_q, state_d;
    req_t                req_q, req_d;
    req_t                req_a;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                ack_q, ack_d;
    logic [31:0]         rdat_q, rdat_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic [31:0]         count_q, count_d;

    logic [31:0]         mem [DEPTH];
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic                in_range;
    logic                is_exit;
    logic                go_ack;
    logic                exit_hit;
    logic                wd_fire;
    logic                mem_we;

    // Next-state, watchdog and response logic. With zero wait states the request
    // is captured and answered on the same edge, so decode uses the live bus in IDLE.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        wcnt_d    = wcnt_q;
        ack_d     = 1'b0;
        rdat_d    = '0;
        done_d    = done_q;
        timeout_d = timeout_q;
        count_d   = count_q;
        go_ack    = 1'b0;
        mem_we    = 1'b0;

        req_a    = (state_q == ST_IDLE) ?
                   {wb_io.adr, wb_io.dat_w, wb_io.sel, wb_io.we} : req_q;
        mem_idx  = req_a.adr[DEPTH_LOG2-1:0];
        is_exit  = (req_a.adr == EXIT_ADR);
        in_range = ({2'b00, req_a.adr} < 32'(DEPTH)) && !is_exit;

        case (state_q)
            ST_IDLE: begin
                if (wb_io.cyc) begin
                    req_d = req_a;
                    if (WAIT_STATES == 0) begin
                        go_ack = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb_io.cyc) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q == '0) begin
                    go_ack = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = done_q ? ST_HALT : ST_IDLE;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        exit_hit = go_ack && is_exit && req_a.we &&
                   (req_a.sel == 4'hF) && (req_a.dat == EXIT_DATA);
        // An exit commit on the same edge as the watchdog takes priority.
        wd_fire  = !done_q && !timeout_q && (count_q == TIMEOUT_LAST) && !exit_hit;

        if (!done_q && !timeout_q) begin
            count_d = count_q + 32'd1;
        end

        if (wd_fire) begin
            timeout_d = 1'b1;
            count_d   = TIMEOUT_FINAL;
            state_d   = ST_HALT;
        end else if (go_ack) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
            if (exit_hit) begin
                done_d = 1'b1;
            end
            if (in_range) begin
                if (req_a.we) begin
                    mem_we = 1'b1;
                end else begin
                    rdat_d = mem[mem_idx];
                end
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            wcnt_q    <= '0;
            ack_q     <= 1'b0;
            rdat_q    <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            wcnt_q    <= wcnt_d;
            ack_q     <= ack_d;
            rdat_q    <= rdat_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    // Byte-lane write port; contents survive reset, a reset edge never commits.
    always_ff @(posedge clk) begin
        if (resetn && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (req_a.sel[b]) begin
                    mem[mem_idx][8*b +: 8] <= req_a.dat[8*b +: 8];
                end
            end
        end
    end

    assign wb_io.ack     = ack_q;
    assign wb_io.dat_r   = rdat_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign cycle_count_o = count_q;

endmodule
